msrh_l1d_lrq: RTL and testbench

- L1D load refill queue (LRQ), directly downstream of the LSU EX2 stage.
- On an L1D miss the LSU pipes present line addresses here. The block allocates or merges refill entries, issues line reads to L2, and writes returned lines into L1D.
- It broadcasts a resolve one-hot so that LDQ/STQ entries parked on LRQ hazards can replay.

---
 rtl/msrh_l1d_lrq.sv | 207 ++++++++++++++++++++
 tb/tb_msrh_l1d_lrq.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msrh_l1d_lrq.sv
// L1D load refill queue: allocates or merges line refills on load misses, issues
// L2 line reads, writes the returned lines into L1D and broadcasts the freed entry.
module msrh_l1d_lrq #(
    parameter int unsigned REQ_PORTS      = 2,
    parameter int unsigned LRQ_ENTRY_SIZE = 8,
    parameter int unsigned PADDR_W        = 56,
    parameter int unsigned DCACHE_DATA_W  = 128,
    parameter int unsigned L2_CMD_TAG_W   = 4
) (
    input  logic                                          i_clk,
    input  logic                                          i_reset,
    input  logic [REQ_PORTS-1:0]                          i_req_valid,
    input  logic [REQ_PORTS-1:0][PADDR_W-1:0]             i_req_paddr,
    output logic [REQ_PORTS-1:0]                          o_resp_full,
    output logic [REQ_PORTS-1:0]                          o_resp_conflict,
    output logic [REQ_PORTS-1:0][LRQ_ENTRY_SIZE-1:0]      o_resp_lrq_index_oh,
    output logic                                          o_l2_req_valid,
    input  logic                                          i_l2_req_ready,
    output logic [4:0]                                    o_l2_req_cmd,
    output logic [PADDR_W-1:0]                            o_l2_req_addr,
    output logic [L2_CMD_TAG_W-1:0]                       o_l2_req_tag,
    output logic [DCACHE_DATA_W-1:0]                      o_l2_req_data,
    output logic [DCACHE_DATA_W/8-1:0]                    o_l2_req_byte_en,
    input  logic                                          i_l2_resp_valid,
    input  logic [L2_CMD_TAG_W-1:0]                       i_l2_resp_tag,
    input  logic [DCACHE_DATA_W-1:0]                      i_l2_resp_data,
    output logic                                          o_dc_update_valid,
    output logic [PADDR_W-1:0]                            o_dc_update_addr,
    output logic [DCACHE_DATA_W-1:0]                      o_dc_update_data,
    output logic [DCACHE_DATA_W/8-1:0]                    o_dc_update_be,
    output logic                                          o_lrq_resolve_valid,
    output logic [LRQ_ENTRY_SIZE-1:0]                     o_lrq_resolve_index_oh
);

    localparam int unsigned OFS_W     = $clog2(DCACHE_DATA_W / 8);
    localparam int unsigned LINE_W    = PADDR_W - OFS_W;
    localparam int unsigned IDX_W     = $clog2(LRQ_ENTRY_SIZE);
    localparam int unsigned TAG_IDX_W = L2_CMD_TAG_W - 1;
    localparam int unsigned BE_W      = DCACHE_DATA_W / 8;
    localparam logic [4:0]  M_XRD     = 5'b00000;

    typedef enum logic [1:0] {
        ST_FREE      = 2'd0,
        ST_WAIT_SEND = 2'd1,
        ST_WAIT_RESP = 2'd2
    } state_t;

    state_t                     state_q [LRQ_ENTRY_SIZE];
    logic [LINE_W-1:0]          line_q  [LRQ_ENTRY_SIZE];
    logic                       dc_valid_q;
    logic [PADDR_W-1:0]         dc_addr_q;
    logic [DCACHE_DATA_W-1:0]   dc_data_q;
    logic [LRQ_ENTRY_SIZE-1:0]  resolve_oh_q;
    logic                       rst_q;

    logic [REQ_PORTS-1:0][LINE_W-1:0]         req_line;
    logic [LRQ_ENTRY_SIZE-1:0]                free_mask;
    logic [LRQ_ENTRY_SIZE-1:0]                send_mask;
    logic [REQ_PORTS-1:0][LRQ_ENTRY_SIZE-1:0] alloc_oh;
    logic [LRQ_ENTRY_SIZE-1:0]                taken;
    logic [LRQ_ENTRY_SIZE-1:0]                hit;
    logic [LRQ_ENTRY_SIZE-1:0]                avail;
    logic [LRQ_ENTRY_SIZE-1:0]                pick;
    logic [LRQ_ENTRY_SIZE-1:0]                alloc_any;
    logic [LINE_W-1:0]                        alloc_line [LRQ_ENTRY_SIZE];
    logic [IDX_W-1:0]                         send_idx;
    logic                                     send_valid;
    logic                                     send_fire;
    logic [IDX_W-1:0]                         resp_idx;
    logic                                     resp_hit;
    logic                                     unused_req_ofs;

    always_comb begin
        unused_req_ofs = 1'b0;
        for (int p = 0; p < REQ_PORTS; p++) begin
            req_line[p]    = i_req_paddr[p][PADDR_W-1:OFS_W];
            unused_req_ofs = unused_req_ofs ^ (^i_req_paddr[p][OFS_W-1:0]);
        end
    end

    always_comb begin
        for (int e = 0; e < LRQ_ENTRY_SIZE; e++) begin
            free_mask[e] = (state_q[e] == ST_FREE);
            send_mask[e] = (state_q[e] == ST_WAIT_SEND);
        end
    end

    // Per-port merge/allocate; lower ports claim entries and lines first.
    always_comb begin
        taken               = '0;
        hit                 = '0;
        avail               = '0;
        pick                = '0;
        alloc_oh            = '0;
        o_resp_full         = '0;
        o_resp_conflict     = '0;
        o_resp_lrq_index_oh = '0;
        for (int p = 0; p < REQ_PORTS; p++) begin
            hit = '0;
            for (int e = 0; e < LRQ_ENTRY_SIZE; e++) begin
                if (!free_mask[e] && (line_q[e] == req_line[p])) begin
                    hit[e] = 1'b1;
                end
            end
            for (int q = 0; q < p; q++) begin
                if (req_line[q] == req_line[p]) begin
                    hit = hit | alloc_oh[q];
                end
            end
            avail = free_mask & ~taken;
            pick  = avail & (~avail + LRQ_ENTRY_SIZE'(1));
            if (i_req_valid[p]) begin
                if (|hit) begin
                    o_resp_conflict[p]     = 1'b1;
                    o_resp_lrq_index_oh[p] = hit;
                end else if (|avail) begin
                    alloc_oh[p]            = pick;
                    o_resp_lrq_index_oh[p] = pick;
                    taken                  = taken | pick;
                end else begin
                    o_resp_full[p] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        alloc_any = '0;
        for (int e = 0; e < LRQ_ENTRY_SIZE; e++) begin
            alloc_line[e] = '0;
            for (int p = 0; p < REQ_PORTS; p++) begin
                if (alloc_oh[p][e]) begin
                    alloc_any[e]  = 1'b1;
                    alloc_line[e] = req_line[p];
                end
            end
        end
    end

    // Lowest-index WAIT_SEND entry owns the L2 request channel.
    always_comb begin
        send_idx = '0;
        for (int e = LRQ_ENTRY_SIZE - 1; e >= 0; e--) begin
            if (send_mask[e]) begin
                send_idx = IDX_W'(e);
            end
        end
    end

    assign send_valid       = |send_mask;
    assign send_fire        = send_valid & i_l2_req_ready;
    assign o_l2_req_valid   = send_valid;
    assign o_l2_req_cmd     = M_XRD;
    assign o_l2_req_addr    = send_valid ? {line_q[send_idx], {OFS_W{1'b0}}} : '0;
    assign o_l2_req_tag     = send_valid ? {1'b1, TAG_IDX_W'(send_idx)} : '0;
    assign o_l2_req_data    = '0;
    assign o_l2_req_byte_en = '1;

    assign resp_idx = i_l2_resp_tag[IDX_W-1:0];
    assign resp_hit = i_l2_resp_valid && i_l2_resp_tag[L2_CMD_TAG_W-1]
                      && (state_q[resp_idx] == ST_WAIT_RESP);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int e = 0; e < LRQ_ENTRY_SIZE; e++) begin
                state_q[e] <= ST_FREE;
                line_q[e]  <= '0;
            end
            dc_valid_q   <= 1'b0;
            dc_addr_q    <= '0;
            dc_data_q    <= '0;
            resolve_oh_q <= '0;
        end else begin
            for (int e = 0; e < LRQ_ENTRY_SIZE; e++) begin
                if (alloc_any[e]) begin
                    state_q[e] <= ST_WAIT_SEND;
                    line_q[e]  <= alloc_line[e];
                end else if (send_fire && (send_idx == IDX_W'(e))) begin
                    state_q[e] <= ST_WAIT_RESP;
                end else if (resp_hit && (resp_idx == IDX_W'(e))) begin
                    state_q[e] <= ST_FREE;
                end
            end
            dc_valid_q   <= resp_hit;
            dc_addr_q    <= resp_hit ? {line_q[resp_idx], {OFS_W{1'b0}}} : '0;
            dc_data_q    <= resp_hit ? i_l2_resp_data : '0;
            resolve_oh_q <= resp_hit ? (LRQ_ENTRY_SIZE'(1) << resp_idx) : '0;
        end
    end

    // Responses racing a reset may target freed entries; only flag them afterwards.
    always_ff @(posedge i_clk) begin
        rst_q <= i_reset;
        if (!i_reset && !rst_q && i_l2_resp_valid && i_l2_resp_tag[L2_CMD_TAG_W-1]) begin
            assert (state_q[resp_idx] == ST_WAIT_RESP)
            else $error("lrq: L2 response for entry %0d not awaiting a response", resp_idx);
        end
    end

    assign o_dc_update_valid      = dc_valid_q;
    assign o_dc_update_addr       = dc_addr_q;
    assign o_dc_update_data       = dc_data_q;
    assign o_dc_update_be         = {BE_W{dc_valid_q}};
    assign o_lrq_resolve_valid    = dc_valid_q;
    assign o_lrq_resolve_index_oh = resolve_oh_q;

endmodule

// File: tb/tb_msrh_l1d_lrq.sv
// Bench for the L1D refill queue: directed scenarios with a scoreboard of
// expected L1D line writes and resolve broadcasts.
module tb_msrh_l1d_lrq;

    logic               clk;
    logic               rst;
    logic [1:0]         req_valid;
    logic [1:0][55:0]   req_paddr;
    logic [1:0]         resp_full;
    logic [1:0]         resp_conflict;
    logic [1:0][7:0]    resp_oh;
    logic               l2_req_valid;
    logic               l2_req_ready;
    logic [4:0]         l2_req_cmd;
    logic [55:0]        l2_req_addr;
    logic [3:0]         l2_req_tag;
    logic [127:0]       l2_req_data;
    logic [15:0]        l2_req_be;
    logic               l2_resp_valid;
    logic [3:0]         l2_resp_tag;
    logic [127:0]       l2_resp_data;
    logic               dc_valid;
    logic [55:0]        dc_addr;
    logic [127:0]       dc_data;
    logic [15:0]        dc_be;
    logic               rsv_valid;
    logic [7:0]         rsv_oh;

    typedef struct packed {
        logic [55:0]  addr;
        logic [127:0] data;
        logic [7:0]   oh;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    msrh_l1d_lrq dut (
        .i_clk                  (clk),
        .i_reset                (rst),
        .i_req_valid            (req_valid),
        .i_req_paddr            (req_paddr),
        .o_resp_full            (resp_full),
        .o_resp_conflict        (resp_conflict),
        .o_resp_lrq_index_oh    (resp_oh),
        .o_l2_req_valid         (l2_req_valid),
        .i_l2_req_ready         (l2_req_ready),
        .o_l2_req_cmd           (l2_req_cmd),
        .o_l2_req_addr          (l2_req_addr),
        .o_l2_req_tag           (l2_req_tag),
        .o_l2_req_data          (l2_req_data),
        .o_l2_req_byte_en       (l2_req_be),
        .i_l2_resp_valid        (l2_resp_valid),
        .i_l2_resp_tag          (l2_resp_tag),
        .i_l2_resp_data         (l2_resp_data),
        .o_dc_update_valid      (dc_valid),
        .o_dc_update_addr       (dc_addr),
        .o_dc_update_data       (dc_data),
        .o_dc_update_be         (dc_be),
        .o_lrq_resolve_valid    (rsv_valid),
        .o_lrq_resolve_index_oh (rsv_oh)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock; the falling edge pops the scoreboard for any line write seen.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (dc_valid || rsv_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL dc_update_unexpected: got addr=%h resolve_oh=%h, expected no update", dc_addr, rsv_oh);
            end else begin
                e = sb.pop_front();
                if (!dc_valid || !rsv_valid || dc_addr !== e.addr || dc_data !== e.data
                    || dc_be !== 16'hffff || rsv_oh !== e.oh) begin
                    errors++;
                    $display("FAIL dc_update: got v=%b/%b addr=%h data=%h be=%h oh=%h, expected addr=%h data=%h be=ffff oh=%h",
                             dc_valid, rsv_valid, dc_addr, dc_data, dc_be, rsv_oh, e.addr, e.data, e.oh);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_resp(input logic [3:0] tag, input logic [55:0] addr, input logic [7:0] oh);
        exp_t e;
        e.addr = addr;
        e.data = {$urandom(), $urandom(), $urandom(), $urandom()};
        e.oh   = oh;
        l2_resp_valid = 1'b1;
        l2_resp_tag   = tag;
        l2_resp_data  = e.data;
        sb.push_back(e);
        tick();
        l2_resp_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (l2_req_valid !== 1'b0 || l2_req_addr !== 56'h0 || l2_req_tag !== 4'h0) begin
            errors++;
            $display("FAIL reset_l2_req: got v=%b addr=%h tag=%h, expected 0/0/0", l2_req_valid, l2_req_addr, l2_req_tag);
        end
        checks++;
        if (dc_valid !== 1'b0 || dc_addr !== 56'h0 || dc_data !== 128'h0 || dc_be !== 16'h0
            || rsv_valid !== 1'b0 || rsv_oh !== 8'h0) begin
            errors++;
            $display("FAIL reset_dc_update: got v=%b addr=%h be=%h rsv=%b oh=%h, expected all 0", dc_valid, dc_addr, dc_be, rsv_valid, rsv_oh);
        end
        checks++;
        if (l2_req_cmd !== 5'h0 || l2_req_data !== 128'h0 || l2_req_be !== 16'hffff) begin
            errors++;
            $display("FAIL reset_l2_const: got cmd=%h data=%h be=%h, expected 0/0/ffff", l2_req_cmd, l2_req_data, l2_req_be);
        end
    endtask

    task automatic test_single_miss();
        l2_req_ready = 1'b1;
        req_valid    = 2'b01;
        req_paddr[0] = 56'h8000_1234;
        #1;
        checks++;
        if (resp_conflict !== 2'b00 || resp_full !== 2'b00 || resp_oh[0] !== 8'h01 || resp_oh[1] !== 8'h00) begin
            errors++;
            $display("FAIL single_resp: got conf=%b full=%b oh0=%h oh1=%h, expected 00/00/01/00", resp_conflict, resp_full, resp_oh[0], resp_oh[1]);
        end
        tick();
        req_valid = 2'b00;
        #1;
        checks++;
        if (l2_req_valid !== 1'b1 || l2_req_addr !== 56'h8000_1230 || l2_req_tag !== 4'h8) begin
            errors++;
            $display("FAIL single_l2_req: got v=%b addr=%h tag=%h, expected 1/80001230/8", l2_req_valid, l2_req_addr, l2_req_tag);
        end
        tick();
        #1;
        checks++;
        if (l2_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_l2_done: got v=%b, expected 0", l2_req_valid);
        end
        // L1D-less tag (MSB clear) must be ignored.
        l2_resp_valid = 1'b1;
        l2_resp_tag   = 4'h0;
        l2_resp_data  = {4{32'hdead_beef}};
        tick();
        send_resp(4'h8, 56'h8000_1230, 8'h01);
        tick();
    endtask

    task automatic test_merge();
        l2_req_ready = 1'b1;
        req_valid    = 2'b11;
        req_paddr[0] = 56'h100;
        req_paddr[1] = 56'h108;
        #1;
        checks++;
        if (resp_conflict !== 2'b10 || resp_full !== 2'b00 || resp_oh[0] !== 8'h01 || resp_oh[1] !== 8'h01) begin
            errors++;
            $display("FAIL merge_resp: got conf=%b full=%b oh0=%h oh1=%h, expected 10/00/01/01", resp_conflict, resp_full, resp_oh[0], resp_oh[1]);
        end
        tick();
        req_valid = 2'b00;
        #1;
        checks++;
        if (l2_req_valid !== 1'b1 || l2_req_addr !== 56'h100 || l2_req_tag !== 4'h8) begin
            errors++;
            $display("FAIL merge_l2_req: got v=%b addr=%h tag=%h, expected 1/100/8", l2_req_valid, l2_req_addr, l2_req_tag);
        end
        tick();
        #1;
        checks++;
        if (l2_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL merge_single_issue: got v=%b tag=%h, expected no second request", l2_req_valid, l2_req_tag);
        end
        send_resp(4'h8, 56'h100, 8'h01);
        tick();
    endtask

    task automatic test_full();
        l2_req_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            req_valid    = 2'b11;
            req_paddr[0] = 56'h10000 + 56'(2 * k) * 56'h40;
            req_paddr[1] = 56'h10000 + 56'(2 * k + 1) * 56'h40;
            #1;
            checks++;
            if (resp_oh[0] !== (8'h01 << (2 * k)) || resp_oh[1] !== (8'h02 << (2 * k)) || resp_conflict !== 2'b00) begin
                errors++;
                $display("FAIL full_fill%0d: got oh0=%h oh1=%h conf=%b", k, resp_oh[0], resp_oh[1], resp_conflict);
            end
            tick();
        end
        req_paddr[0] = 56'h20000;
        req_paddr[1] = 56'h100C5;
        #1;
        checks++;
        if (resp_full !== 2'b01 || resp_conflict !== 2'b10 || resp_oh[0] !== 8'h00 || resp_oh[1] !== 8'h08) begin
            errors++;
            $display("FAIL full_ninth: got full=%b conf=%b oh0=%h oh1=%h, expected 01/10/00/08", resp_full, resp_conflict, resp_oh[0], resp_oh[1]);
        end
        tick();
        req_valid    = 2'b00;
        l2_req_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            checks++;
            if (l2_req_valid !== 1'b1 || l2_req_tag !== (4'h8 + 4'(k)) || l2_req_addr !== (56'h10000 + 56'(k) * 56'h40)) begin
                errors++;
                $display("FAIL full_drain%0d: got v=%b addr=%h tag=%h", k, l2_req_valid, l2_req_addr, l2_req_tag);
            end
            tick();
        end
        #1;
        checks++;
        if (l2_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_dropped: got v=%b addr=%h, expected dropped request not issued", l2_req_valid, l2_req_addr);
        end
        for (int k = 0; k < 8; k++) begin
            send_resp(4'h8 + 4'(k), 56'h10000 + 56'(k) * 56'h40, 8'h01 << k);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        l2_req_ready = 1'b0;
        req_valid    = 2'b11;
        req_paddr[0] = 56'h3000;
        req_paddr[1] = 56'h3010;
        tick();
        req_valid = 2'b00;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (l2_req_valid !== 1'b1 || l2_req_addr !== 56'h3000 || l2_req_tag !== 4'h8) begin
                errors++;
                $display("FAIL bp_hold%0d: got v=%b addr=%h tag=%h, expected 1/3000/8", i, l2_req_valid, l2_req_addr, l2_req_tag);
            end
            tick();
        end
        l2_req_ready = 1'b1;
        #1;
        checks++;
        if (l2_req_valid !== 1'b1 || l2_req_addr !== 56'h3000 || l2_req_tag !== 4'h8) begin
            errors++;
            $display("FAIL bp_first: got v=%b addr=%h tag=%h, expected 1/3000/8", l2_req_valid, l2_req_addr, l2_req_tag);
        end
        tick();
        #1;
        checks++;
        if (l2_req_valid !== 1'b1 || l2_req_addr !== 56'h3010 || l2_req_tag !== 4'h9) begin
            errors++;
            $display("FAIL bp_second: got v=%b addr=%h tag=%h, expected 1/3010/9", l2_req_valid, l2_req_addr, l2_req_tag);
        end
        tick();
        send_resp(4'h8, 56'h3000, 8'h01);
        send_resp(4'h9, 56'h3010, 8'h02);
        tick();
    endtask

    task automatic test_race();
        l2_req_ready = 1'b1;
        req_valid    = 2'b11;
        req_paddr[0] = 56'h5000;
        req_paddr[1] = 56'h5040;
        tick();
        req_valid    = 2'b01;
        req_paddr[0] = 56'h5080;
        tick();
        req_valid = 2'b00;
        tick();
        tick();
        tick();
        l2_resp_valid = 1'b0;
        req_valid     = 2'b01;
        req_paddr[0]  = 56'h5088;
        #1;
        checks++;
        if (resp_conflict[0] !== 1'b1 || resp_full[0] !== 1'b0 || resp_oh[0] !== 8'h04) begin
            errors++;
            $display("FAIL race_conflict: got conf=%b full=%b oh=%h, expected 1/0/04", resp_conflict[0], resp_full[0], resp_oh[0]);
        end
        send_resp(4'hA, 56'h5080, 8'h04);
        req_paddr[0] = 56'h6000;
        #1;
        checks++;
        if (resp_conflict[0] !== 1'b0 || resp_full[0] !== 1'b0 || resp_oh[0] !== 8'h04) begin
            errors++;
            $display("FAIL race_freed: got conf=%b full=%b oh=%h, expected 0/0/04", resp_conflict[0], resp_full[0], resp_oh[0]);
        end
        tick();
        req_valid = 2'b00;
        tick();
        tick();
        send_resp(4'h8, 56'h5000, 8'h01);
        send_resp(4'h9, 56'h5040, 8'h02);
        send_resp(4'hA, 56'h6000, 8'h04);
        tick();
    endtask

    task automatic test_reset_mid();
        l2_req_ready = 1'b1;
        req_valid    = 2'b11;
        req_paddr[0] = 56'h7000;
        req_paddr[1] = 56'h7040;
        tick();
        req_valid = 2'b00;
        tick();
        tick();
        tick();
        rst           = 1'b1;
        l2_resp_valid = 1'b1;
        l2_resp_tag   = 4'h8;
        l2_resp_data  = {4{32'h1234_5678}};
        tick();
        rst         = 1'b0;
        l2_resp_tag = 4'h9;
        tick();
        l2_resp_valid = 1'b0;
        req_valid     = 2'b01;
        req_paddr[0]  = 56'h7000;
        #1;
        checks++;
        if (l2_req_valid !== 1'b0 || resp_conflict[0] !== 1'b0 || resp_oh[0] !== 8'h01) begin
            errors++;
            $display("FAIL reset_mid_free: got l2v=%b conf=%b oh=%h, expected 0/0/01", l2_req_valid, resp_conflict[0], resp_oh[0]);
        end
        req_valid = 2'b00;
        tick();
        tick();
    endtask

    initial begin
        rst           = 1'b1;
        req_valid     = 2'b00;
        req_paddr     = '0;
        l2_req_ready  = 1'b0;
        l2_resp_valid = 1'b0;
        l2_resp_tag   = 4'h0;
        l2_resp_data  = '0;
        @(posedge clk);
        #1;
        tick();
        tick();
        rst = 1'b0;
        test_reset();
        tick();
        test_single_miss();
        test_merge();
        test_full();
        test_back_to_back();
        test_race();
        test_reset_mid();
        tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d outstanding line writes, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
